// File: rtl/mc_ctrl_fsm_if.sv
// Control/status bundle between the multi-cycle sequencer (master) and the datapath (slave).
interface mc_ctrl_fsm_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       iord;
    logic       mem_rd;
    logic       mem_wr;
    logic       mem2reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic       ext_op;
    logic [1:0] pc_src;
    logic [3:0] state;
    logic       illegal_op;
    logic       mem_timeout;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_write, pc_write_cond, ir_write, iord, mem_rd, mem_wr, mem2reg,
               reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, ext_op, pc_src,
               state, illegal_op, mem_timeout
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_write, pc_write_cond, ir_write, iord, mem_rd, mem_wr, mem2reg,
               reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, ext_op, pc_src,
               state, illegal_op, mem_timeout
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS-subset control sequencer with memory-wait timeout flag.
// Optional MC_CTRL_ILLEGAL_HALT_EN: illegal instructions park the FSM in HALT until reset.
module mc_ctrl_fsm #(
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned CNT_W    = 4
) (
    input  logic          clk,
    input  logic          rst,
    mc_ctrl_fsm_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEM_ADDR = 4'd2, S_MEM_RD = 4'd3,
        S_MEM_WB = 4'd4, S_MEM_WR = 4'd5, S_R_EXEC = 4'd6, S_R_WB = 4'd7,
        S_BRANCH = 4'd8, S_JUMP = 4'd9, S_I_EXEC = 4'd10, S_I_WB = 4'd11,
        S_HALT = 4'd12
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                           ALU_XOR = 4'd4, ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_SLTU = 4'd7,
                           ALU_LUI = 4'd8;
    localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000,
                           OP_ORI = 6'b001101, OP_LUI = 6'b001111;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_SAT = '1;

`ifdef MC_CTRL_ILLEGAL_HALT_EN
    localparam state_t S_TRAP = S_HALT;
`else
    localparam state_t S_TRAP = S_FETCH;
`endif

    state_t           r_state, w_next_state;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_illegal, r_timeout;
    logic             w_illegal_evt, w_waiting, w_r_legal, w_i_ext;
    logic [3:0]       w_r_alu_op, w_i_alu_op;
    logic             w_pc_write, w_pc_write_cond, w_ir_write, w_iord, w_mem_rd, w_mem_wr;
    logic             w_mem2reg, w_reg_dst, w_reg_write, w_alu_src_a, w_ext_op;
    logic [1:0]       w_alu_src_b, w_pc_src;
    logic [3:0]       w_alu_op;
    logic             w_unused_zero;

    // zero is consumed by the datapath through pc_write_cond, not by the sequencer
    assign w_unused_zero = bus.zero;

    always_comb begin
        w_r_legal  = 1'b1;
        w_r_alu_op = ALU_ADD;
        case (bus.funct)
            6'b100001: w_r_alu_op = ALU_ADD;
            6'b100011: w_r_alu_op = ALU_SUB;
            6'b100100: w_r_alu_op = ALU_AND;
            6'b100101: w_r_alu_op = ALU_OR;
            6'b100110: w_r_alu_op = ALU_XOR;
            6'b100111: w_r_alu_op = ALU_NOR;
            6'b101010: w_r_alu_op = ALU_SLT;
            6'b101011: w_r_alu_op = ALU_SLTU;
            default:   w_r_legal  = 1'b0;
        endcase
    end

    always_comb begin
        w_i_alu_op = ALU_ADD;
        w_i_ext    = 1'b1;
        case (bus.opcode)
            OP_ORI:  begin w_i_alu_op = ALU_OR;  w_i_ext = 1'b0; end
            OP_LUI:  begin w_i_alu_op = ALU_LUI; w_i_ext = 1'b0; end
            default: begin w_i_alu_op = ALU_ADD; w_i_ext = 1'b1; end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state  = r_state;
        w_illegal_evt = 1'b0;
        case (r_state)
            S_FETCH:    if (bus.mem_ready) w_next_state = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:              w_next_state = S_R_EXEC;
                    OP_LW, OP_SW:          w_next_state = S_MEM_ADDR;
                    OP_BEQ:                w_next_state = S_BRANCH;
                    OP_J:                  w_next_state = S_JUMP;
                    OP_ADDI, OP_ORI, OP_LUI: w_next_state = S_I_EXEC;
                    default: begin
                        w_illegal_evt = 1'b1;
                        w_next_state  = S_TRAP;
                    end
                endcase
            end
            S_MEM_ADDR: w_next_state = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (bus.mem_ready) w_next_state = S_MEM_WB;
            S_MEM_WR:   if (bus.mem_ready) w_next_state = S_FETCH;
            S_R_EXEC: begin
                if (w_r_legal) begin
                    w_next_state = S_R_WB;
                end else begin
                    w_illegal_evt = 1'b1;
                    w_next_state  = S_TRAP;
                end
            end
            S_I_EXEC:   w_next_state = S_I_WB;
            S_HALT:     w_next_state = S_HALT;
            default:    w_next_state = S_FETCH;
        endcase
    end

    always_comb begin
        w_pc_write = 1'b0; w_pc_write_cond = 1'b0; w_ir_write = 1'b0; w_iord = 1'b0;
        w_mem_rd = 1'b0; w_mem_wr = 1'b0; w_mem2reg = 1'b0; w_reg_dst = 1'b0;
        w_reg_write = 1'b0; w_alu_src_a = 1'b0; w_alu_src_b = 2'b00; w_alu_op = ALU_ADD;
        w_ext_op = 1'b0; w_pc_src = 2'b00;
        case (r_state)
            S_FETCH: begin
                // IR and PC+4 commit only on the cycle memory delivers the word
                w_mem_rd    = 1'b1;
                w_alu_src_b = 2'b01;
                w_ir_write  = bus.mem_ready & ~rst;
                w_pc_write  = bus.mem_ready & ~rst;
            end
            S_DECODE:   begin w_alu_src_b = 2'b11; w_ext_op = 1'b1; end
            S_MEM_ADDR: begin w_alu_src_a = 1'b1; w_alu_src_b = 2'b10; w_ext_op = 1'b1; end
            S_MEM_RD:   begin w_iord = 1'b1; w_mem_rd = 1'b1; end
            S_MEM_WB:   begin w_reg_write = 1'b1; w_mem2reg = 1'b1; end
            S_MEM_WR:   begin w_iord = 1'b1; w_mem_wr = 1'b1; end
            S_R_EXEC:   begin w_alu_src_a = 1'b1; w_alu_op = w_r_alu_op; end
            S_R_WB:     begin w_reg_write = 1'b1; w_reg_dst = 1'b1; w_alu_op = w_r_alu_op; end
            S_BRANCH: begin
                w_alu_src_a = 1'b1; w_alu_op = ALU_SUB; w_pc_src = 2'b01; w_pc_write_cond = 1'b1;
            end
            S_JUMP:     begin w_pc_src = 2'b10; w_pc_write = 1'b1; end
            S_I_EXEC: begin
                w_alu_src_a = 1'b1; w_alu_src_b = 2'b10; w_alu_op = w_i_alu_op; w_ext_op = w_i_ext;
            end
            S_I_WB:     begin w_reg_write = 1'b1; w_alu_op = w_i_alu_op; w_ext_op = w_i_ext; end
            default:    begin end
        endcase
    end

    assign w_waiting = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);

    // Wait counter restarts on every state change; flags are sticky until reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
            r_illegal  <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            if (w_next_state != r_state)
                r_wait_cnt <= '0;
            else if (w_waiting && !bus.mem_ready && (r_wait_cnt != CNT_SAT))
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            if (w_illegal_evt)
                r_illegal <= 1'b1;
            if (w_waiting && (r_wait_cnt >= CNT_MAX))
                r_timeout <= 1'b1;
        end
    end

    assign bus.pc_write      = w_pc_write;
    assign bus.pc_write_cond = w_pc_write_cond;
    assign bus.ir_write      = w_ir_write;
    assign bus.iord          = w_iord;
    assign bus.mem_rd        = w_mem_rd;
    assign bus.mem_wr        = w_mem_wr;
    assign bus.mem2reg       = w_mem2reg;
    assign bus.reg_dst       = w_reg_dst;
    assign bus.reg_write     = w_reg_write;
    assign bus.alu_src_a     = w_alu_src_a;
    assign bus.alu_src_b     = w_alu_src_b;
    assign bus.alu_op        = w_alu_op;
    assign bus.ext_op        = w_ext_op;
    assign bus.pc_src        = w_pc_src;
    assign bus.state         = r_state;
    assign bus.illegal_op    = r_illegal;
    assign bus.mem_timeout   = r_timeout;
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: per-instruction state sequences plus a per-state control table.
module tb_mc_ctrl_fsm;
    localparam int unsigned MAX_WAIT = 15;
    localparam int unsigned HALT_CYC = 3;

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEM_ADDR = 4'd2, S_MEM_RD = 4'd3,
                           S_MEM_WB = 4'd4, S_MEM_WR = 4'd5, S_R_EXEC = 4'd6, S_R_WB = 4'd7,
                           S_BRANCH = 4'd8, S_JUMP = 4'd9, S_I_EXEC = 4'd10, S_I_WB = 4'd11,
                           S_HALT = 4'd12;
    localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000,
                           OP_ORI = 6'b001101, OP_LUI = 6'b001111;

    logic clk = 1'b0;
    logic rst;
    mc_ctrl_fsm_if bus();

    mc_ctrl_fsm #(.MAX_WAIT(MAX_WAIT), .CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    logic [24:0] obs_vec, exp_vec;
    logic        exp_illegal, exp_timeout;
    int          run;
    logic [3:0]  q_st[$];
    logic        q_rdy[$];
    logic [5:0]  fn_tab[8] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b};
    logic [5:0]  op_tab[8] = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ORI, OP_LUI};

    // ALU op for an R-type funct is its position in the funct table (ADD..SLTU)
    function automatic int fn_idx(input logic [5:0] fn);
        for (int i = 0; i < 8; i++) if (fn_tab[i] == fn) return i;
        return -1;
    endfunction

    function automatic logic op_legal(input logic [5:0] op);
        for (int i = 0; i < 8; i++) if (op_tab[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [4:0] i_alu(input logic [5:0] op);
        if (op == OP_ORI) return {4'd3, 1'b0};
        if (op == OP_LUI) return {4'd8, 1'b0};
        return {4'd0, 1'b1};
    endfunction

    function automatic logic [18:0] ctrl(input logic [3:0] st, input logic [5:0] op,
                                         input logic [5:0] fn, input logic rdy);
        logic pcw, pcwc, irw, iord, mrd, mwr, m2r, rdst, rw, asa, ext;
        logic [1:0] asb, psrc;
        logic [3:0] aop;
        int idx;
        {pcw, pcwc, irw, iord, mrd, mwr, m2r, rdst, rw, asa, ext} = '0;
        asb = 2'b00; psrc = 2'b00; aop = 4'd0;
        idx = fn_idx(fn);
        case (st)
            S_FETCH:    begin mrd = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
            S_DECODE:   begin asb = 2'b11; ext = 1; end
            S_MEM_ADDR: begin asa = 1; asb = 2'b10; ext = 1; end
            S_MEM_RD:   begin iord = 1; mrd = 1; end
            S_MEM_WB:   begin rw = 1; m2r = 1; end
            S_MEM_WR:   begin iord = 1; mwr = 1; end
            S_R_EXEC:   begin asa = 1; aop = (idx < 0) ? 4'd0 : 4'(idx); end
            S_R_WB:     begin rw = 1; rdst = 1; aop = (idx < 0) ? 4'd0 : 4'(idx); end
            S_BRANCH:   begin asa = 1; aop = 4'd1; psrc = 2'b01; pcwc = 1; end
            S_JUMP:     begin psrc = 2'b10; pcw = 1; end
            S_I_EXEC:   begin asa = 1; asb = 2'b10; {aop, ext} = i_alu(op); end
            S_I_WB:     begin rw = 1; {aop, ext} = i_alu(op); end
            default:    begin end
        endcase
        return {pcw, pcwc, irw, iord, mrd, mwr, m2r, rdst, rw, asa, asb, aop, ext, psrc};
    endfunction

    function automatic logic [24:0] get_obs();
        return {bus.state, bus.pc_write, bus.pc_write_cond, bus.ir_write, bus.iord, bus.mem_rd,
                bus.mem_wr, bus.mem2reg, bus.reg_dst, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
                bus.alu_op, bus.ext_op, bus.pc_src, bus.illegal_op, bus.mem_timeout};
    endfunction

    // Expected state walk of one instruction; wf/wm are not-ready cycles in fetch/memory
    task automatic build_seq(input logic [5:0] op, input logic [5:0] fn,
                             input int wf, input int wm, input logic rnd);
        logic legal_tail;
        q_st.delete(); q_rdy.delete();
        bus.opcode = op; bus.funct = fn;
        legal_tail = 1'b1;
        for (int i = 0; i < wf; i++) begin q_st.push_back(S_FETCH); q_rdy.push_back(1'b0); end
        q_st.push_back(S_FETCH); q_rdy.push_back(1'b1);
        q_st.push_back(S_DECODE);
        case (op)
            OP_RTYPE: begin
                q_st.push_back(S_R_EXEC);
                if (fn_idx(fn) >= 0) q_st.push_back(S_R_WB); else legal_tail = 1'b0;
            end
            OP_LW: begin
                q_st.push_back(S_MEM_ADDR);
                for (int i = 0; i < wm; i++) begin q_st.push_back(S_MEM_RD); end
                q_st.push_back(S_MEM_RD);
                q_st.push_back(S_MEM_WB);
            end
            OP_SW: begin
                q_st.push_back(S_MEM_ADDR);
                for (int i = 0; i <= wm; i++) q_st.push_back(S_MEM_WR);
            end
            OP_BEQ:                  q_st.push_back(S_BRANCH);
            OP_J:                    q_st.push_back(S_JUMP);
            OP_ADDI, OP_ORI, OP_LUI: begin q_st.push_back(S_I_EXEC); q_st.push_back(S_I_WB); end
            default:                 legal_tail = 1'b0;
        endcase
`ifdef MC_CTRL_ILLEGAL_HALT_EN
        if (!legal_tail) for (int i = 0; i < HALT_CYC; i++) q_st.push_back(S_HALT);
`else
        if (!legal_tail) q_st.push_back(S_FETCH);
        if (!legal_tail) void'(q_st.pop_back());
`endif
        // memory phases: ready only on the last cycle of each wait run; elsewhere random
        for (int i = q_rdy.size(); i < q_st.size(); i++) begin
            if ((q_st[i] == S_MEM_RD || q_st[i] == S_MEM_WR))
                q_rdy.push_back((i + 1 < q_st.size()) ? (q_st[i+1] != q_st[i]) : 1'b1);
            else
                q_rdy.push_back(rnd ? 1'($urandom) : 1'b1);
        end
    endtask

    task automatic model_update(input logic [3:0] st, input logic rdy);
        if ((st == S_DECODE && !op_legal(bus.opcode)) || (st == S_R_EXEC && fn_idx(bus.funct) < 0))
            exp_illegal = 1'b1;
        if (st == S_FETCH || st == S_MEM_RD || st == S_MEM_WR) begin
            if (run >= int'(MAX_WAIT)) exp_timeout = 1'b1;
            run = rdy ? 0 : run + 1;
        end else begin
            run = 0;
        end
    endtask

    task automatic step(input logic [3:0] st, input logic rdy);
        bus.mem_ready = rdy;
        bus.zero      = 1'($urandom);
        @(negedge clk);
        obs_vec = get_obs();
        exp_vec = {st, ctrl(st, bus.opcode, bus.funct, rdy), exp_illegal, exp_timeout};
        model_update(st, rdy);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_illegal = 1'b0; exp_timeout = 1'b0; run = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.mem_ready = 1'b1; bus.opcode = OP_LW; bus.funct = 6'h00; bus.zero = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (get_obs() !== {S_FETCH, ctrl(S_FETCH, OP_LW, 6'h00, 1'b0), 2'b00}) begin
            n_miss++;
            $display("FAIL reset_hold got %h want %h", get_obs(), {S_FETCH, ctrl(S_FETCH, OP_LW, 6'h00, 1'b0), 2'b00});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        exp_illegal = 1'b0; exp_timeout = 1'b0; run = 0;
    endtask

    task automatic test_addu();
        build_seq(OP_RTYPE, 6'h21, 0, 0, 1'b0);
        for (int i = 0; i < q_st.size(); i++) begin
            step(q_st[i], q_rdy[i]);
            n_vec++;
            if (obs_vec !== exp_vec) begin
                n_miss++;
                $display("FAIL addu cyc %0d got %h want %h", i, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_lw_wait();
        build_seq(OP_LW, 6'h00, 0, 3, 1'b1);
        for (int i = 0; i < q_st.size(); i++) begin
            step(q_st[i], q_rdy[i]);
            n_vec++;
            if (obs_vec !== exp_vec) begin
                n_miss++;
                $display("FAIL lw_wait cyc %0d got %h want %h", i, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_branch_jump();
        for (int k = 0; k < 2; k++) begin
            build_seq((k == 0) ? OP_BEQ : OP_J, 6'(k), 0, 0, 1'b1);
            for (int i = 0; i < q_st.size(); i++) begin
                step(q_st[i], q_rdy[i]);
                n_vec++;
                if (obs_vec !== exp_vec) begin
                    n_miss++;
                    $display("FAIL branch_jump k%0d cyc %0d got %h want %h", k, i, obs_vec, exp_vec);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            build_seq(op_tab[$urandom_range(7)], fn_tab[$urandom_range(7)],
                      int'($urandom_range(4)), int'($urandom_range(4)), 1'b1);
            for (int i = 0; i < q_st.size(); i++) begin
                step(q_st[i], q_rdy[i]);
                n_vec++;
                if (obs_vec !== exp_vec) begin
                    n_miss++;
                    $display("FAIL random ins %0d cyc %0d got %h want %h", n, i, obs_vec, exp_vec);
                end
            end
        end
    endtask

    task automatic test_timeout();
        // 14 waits stays below the limit; 16 waits in fetch must raise the flag
        for (int k = 0; k < 2; k++) begin
            build_seq((k == 0) ? OP_ADDI : OP_ORI, 6'h00, (k == 0) ? 14 : 16, 0, 1'b1);
            for (int i = 0; i < q_st.size(); i++) begin
                step(q_st[i], q_rdy[i]);
                n_vec++;
                if (obs_vec !== exp_vec) begin
                    n_miss++;
                    $display("FAIL timeout k%0d cyc %0d got %h want %h", k, i, obs_vec, exp_vec);
                end
            end
        end
        do_reset();
    endtask

    task automatic test_illegal();
        logic [5:0] ops[3] = '{6'h3f, OP_RTYPE, OP_RTYPE};
        logic [5:0] fns[3] = '{6'h00, 6'h00, 6'h21};
        for (int k = 0; k < 3; k++) begin
            build_seq(ops[k], fns[k], 0, 0, 1'b1);
            for (int i = 0; i < q_st.size(); i++) begin
                step(q_st[i], q_rdy[i]);
                n_vec++;
                if (obs_vec !== exp_vec) begin
                    n_miss++;
                    $display("FAIL illegal k%0d cyc %0d got %h want %h", k, i, obs_vec, exp_vec);
                end
            end
`ifdef MC_CTRL_ILLEGAL_HALT_EN
            if (k < 2) do_reset();
`endif
        end
        do_reset();
    endtask

    task automatic test_reset_mid_mem();
        logic [24:0] want;
        build_seq(OP_LW, 6'h00, 0, 20, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step(q_st[i], q_rdy[i]);
            n_vec++;
            if (obs_vec !== exp_vec) begin
                n_miss++;
                $display("FAIL mid_mem cyc %0d got %h want %h", i, obs_vec, exp_vec);
            end
        end
        bus.mem_ready = 1'b1;
        #3;
        want = {S_MEM_RD, ctrl(S_MEM_RD, OP_LW, 6'h00, 1'b1), exp_illegal, 1'b1};
        n_vec++;
        if (get_obs() !== want) begin
            n_miss++;
            $display("FAIL mid_mem_pre got %h want %h", get_obs(), want);
        end
        rst = 1'b1;
        #1;
        want = {S_FETCH, ctrl(S_FETCH, OP_LW, 6'h00, 1'b0), 2'b00};
        n_vec++;
        if (get_obs() !== want) begin
            n_miss++;
            $display("FAIL mid_mem_async got %h want %h", get_obs(), want);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        exp_illegal = 1'b0; exp_timeout = 1'b0; run = 0;
        test_addu();
    endtask

    initial begin
        test_reset();
        test_addu();
        test_lw_wait();
        test_branch_jump();
        test_random();
        test_timeout();
        test_illegal();
        test_reset_mid_mem();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multi-cycle control sequencer for the MIPS-subset CPU datapath (shared ALU, unified instruction/data memory, IR, PC, register file).
- Decodes OpCode/Funct once per instruction and drives per-state datapath enables.
- Stalls on a memory ready handshake.
- A wait counter flags memory that never responds.

Parameters:
- MAX_WAIT, 15: maximum consecutive cycles a memory access may wait on mem_ready before mem_timeout asserts.
- CNT_W, 4: width of the wait counter; must satisfy 2^CNT_W > MAX_WAIT.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completed the current read/write this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if zero=1 (BEQ)
- ir_write  out  1  IR load
- iord  out  1  memory address select: 0=PC, 1=ALUOut
- mem_rd  out  1  memory read request
- mem_wr  out  1  memory write request
- mem2reg  out  1  register write data select: 1=MDR, 0=ALUOut
- reg_dst  out  1  destination select: 1=rd, 0=rt
- reg_write  out  1  register file write
- alu_src_a  out  1  0=PC, 1=A
- alu_src_b  out  2  00=B, 01=const 4, 10=ext imm, 11=sign-ext imm<<2
- alu_op  out  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 NOR, 0110 SLT, 0111 SLTU, 1000 LUI
- ext_op  out  1  1=sign-extend imm, 0=zero-extend
- pc_src  out  2  00=ALU result, 01=ALUOut, 10=jump target
- state  out  4  current state, for debug
- illegal_op  out  1  sticky, set on an unsupported opcode/funct
- mem_timeout  out  1  sticky, set when wait count exceeds MAX_WAIT

Behaviour:
- Reset: rst=1 asynchronously forces state=FETCH, wait counter=0, illegal_op=0, mem_timeout=0.
- Reset: all other outputs decode from FETCH, so mem_rd=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=ADD; every write enable is 0 while rst=1.
- Outputs are Moore-decoded from state. The exceptions are ir_write, pc_write in FETCH and the handshake-qualified advances.
- Any output not listed for a state is 0.
- State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11, HALT=12.
- FETCH: mem_rd=1, alu_src_b=01, ADD, pc_src=00. ir_write=pc_write=mem_ready. Advances to DECODE when mem_ready=1, otherwise holds.
- DECODE: alu_src_b=11, ADD, ext_op=1 (precomputes branch target). Next state by opcode:
  - 000000 -> R_EXEC
  - 100011 (LW), 101011 (SW) -> MEM_ADDR
  - 000100 (BEQ) -> BRANCH
  - 000010 (J) -> JUMP
  - 001000 (ADDI), 001101 (ORI), 001111 (LUI) -> I_EXEC
  - anything else -> illegal handling
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ext_op=1, ADD. Goes to MEM_RD for LW, MEM_WR for SW.
- MEM_RD: iord=1, mem_rd=1. Holds until mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, mem2reg=1, reg_dst=0. Then FETCH.
- MEM_WR: iord=1, mem_wr=1. Holds until mem_ready, then FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00. alu_op from funct: 100001->ADD, 100011->SUB, 100100->AND, 100101->OR, 100110->XOR, 100111->NOR, 101010->SLT, 101011->SLTU. Any other funct -> illegal handling. Valid funct goes to R_WB.
- R_WB: reg_write=1, reg_dst=1. alu_op keeps the funct decode. Then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_src=01, pc_write_cond=1. Then FETCH.
- JUMP: pc_src=10, pc_write=1. Then FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10.
  - ADDI: ADD, ext_op=1.
  - ORI: OR, ext_op=0.
  - LUI: LUI, ext_op=0.
  - Then I_WB.
- I_WB: reg_write=1, reg_dst=0. alu_op and ext_op hold the I_EXEC values. Then FETCH.
- Wait counter:
  - Cleared on every state change.
  - Increments (saturating at all-ones) each cycle spent in FETCH, MEM_RD or MEM_WR with mem_ready=0.
  - mem_timeout sets when the counter reaches MAX_WAIT with mem_ready still 0.
  - The FSM keeps waiting after timeout; timeout is a flag only.
- Simultaneous events: rst overrides everything. mem_ready arriving on the same cycle mem_timeout would set still advances the FSM and still sets the flag.
- Sticky flags clear only on rst.

Optional Feature:
- Macro: MC_CTRL_ILLEGAL_HALT_EN.
- Defined: illegal handling sets illegal_op and enters HALT. HALT has no enables asserted, mem_rd=0, and is held until rst.
- Undefined: illegal handling sets illegal_op and returns to FETCH, executing the instruction as a NOP. HALT is unreachable.

Test Plan:
- rst pulse mid-MEM_RD (state=3) -> state=0 immediately (asynchronous), flags=0, mem_rd=1, iord=0.
- ADDU (opcode 000000, funct 100001), mem_ready=1 every cycle -> states 0,1,6,7,0; reg_write=1, reg_dst=1 only in state 7; alu_op=0000.
- LW with mem_ready low for 3 cycles in MEM_RD -> state 3 held 4 cycles, counter 0..3, then MEM_WB with mem2reg=1, reg_write=1; total 8 cycles.
- BEQ -> pc_write_cond=1, pc_src=01, alu_op=0001 in state 8 only; J -> pc_write=1, pc_src=10 in state 9.
- mem_ready held 0 in FETCH for 16 cycles (MAX_WAIT=15) -> mem_timeout rises; state stays 0; ir_write=0 throughout.
- opcode 111111 -> illegal_op=1; with MC_CTRL_ILLEGAL_HALT_EN state=12 thereafter; without it, next state=0 and the following instruction executes normally.
